r88_int_sequencer: RTL and testbench
====================================

Name: r88_int_sequencer

Overview:
- Interrupt and reset sequencer for the Rocket88 core.
- Arbitrates reset, NMI and IRQ requests and takes control at instruction boundaries.
- Drives the memory-controller request channel to push PC and flags onto the stack, then fetches the 16-bit vector.
- Ends each service sequence by handing the new PC to the register block. The rest of the core is held off via cpuHold.

Parameters:
- RESET_VEC, 16'hFFFC, address of the reset vector low byte (high byte at +1).
- NMI_VEC, 16'hFFFA, address of the NMI vector low byte.
- IRQ_VEC, 16'hFFFE, address of the IRQ vector low byte.

Ports:
- sysClock  in  1  system clock; all logic on the rising edge.
- resetReqN  in  1  asynchronous active-low reset.
- nmiReq  in  1  NMI request, asynchronous; rising-edge triggered.
- irq  in  1  maskable interrupt request, asynchronous; level sensitive.
- irqMask  in  1  interrupt-disable flag from the flag register; 1 = IRQ ignored.
- instrDone  in  1  one-cycle pulse at the instruction boundary from the decoder.
- pc  in  16  current program counter.
- sp  in  16  current stack pointer.
- flags  in  8  current flag register.
- memAck  in  1  memory controller has accepted or completed the current transfer.
- memRData  in  8  read data, valid in the memAck cycle of a read.
- memReq  out  1  transfer request.
- memWe  out  1  1 = write, 0 = read.
- memAddr  out  16  transfer address.
- memWData  out  8  write data.
- spDec  out  1  one-cycle pulse: stack pointer decrement by 1.
- pcLoad  out  1  one-cycle pulse: load newPc into the PC.
- newPc  out  16  vector value, valid while pcLoad = 1.
- setMask  out  1  one-cycle pulse: set irqMask (NMI and IRQ entry).
- cpuHold  out  1  core stall, high while a sequence runs.

Behaviour:
- Reset (resetReqN low, asynchronous):
  - State is RST_VEC_LO.
  - All pulse outputs are 0.
  - memReq = 0, memWe = 0, memAddr = 0, memWData = 0, newPc = 0.
  - cpuHold = 1.
  - NMI pending flag and sync flops cleared.
- After reset release, the reset sequence runs RST_VEC_LO -> RST_VEC_HI -> LOAD_PC with no pushes.
- Synchronisation:
  - nmiReq and irq each pass through a 2-flop synchroniser.
  - An NMI rising edge (sync low->high) sets nmiPend. nmiPend clears on entry to PUSH_PCH for an NMI.
  - An edge arriving during a sequence remains pending (single-deep; further edges are lost until it clears).
- Arbitration in IDLE, evaluated only on a cycle with instrDone = 1:
  - nmiPend wins over irq.
  - irq is taken if sync irq = 1 and irqMask = 0.
  - Otherwise the state stays IDLE.
  - The selected source latches the vector (NMI_VEC or IRQ_VEC).
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_FL, VEC_LO, VEC_HI, LOAD_PC, RST_VEC_LO, RST_VEC_HI.
  - Interrupt path: IDLE -> PUSH_PCH -> PUSH_PCL -> PUSH_FL -> VEC_LO -> VEC_HI -> LOAD_PC -> IDLE.
- Memory handshake:
  - In every memory state, memReq = 1 with stable memAddr, memWe and memWData.
  - The state advances on the rising edge where memAck = 1. With no ack, the state waits indefinitely.
  - Back-to-back requests are legal; memReq may stay high across states.
  - memAck while memReq = 0 is ignored.
- Pushes (memWe = 1), pre-decrement, addresses from the sp input: sp-1, sp-2, sp-3 with 16-bit wrap (sp = 0 -> 16'hFFFF).
  - PUSH_PCH writes pc[15:8]; PUSH_PCL writes pc[7:0]; PUSH_FL writes flags.
  - pc is captured in the arbitration cycle.
  - Each accepted push pulses spDec in the cycle after memAck.
  - sp is owned externally; pushes use sp captured at entry minus an internal offset.
- Vector reads (memWe = 0):
  - VEC_LO reads the vector address and latches memRData into newPc[7:0].
  - VEC_HI reads the vector address + 1 and latches into newPc[15:8].
- LOAD_PC lasts exactly one cycle:
  - pcLoad = 1 and memReq = 0.
  - setMask = 1 for NMI/IRQ only, not for reset.
  - The next cycle is IDLE.
- cpuHold = 1 in every state except IDLE.
- IRQ latency: from instrDone (cycle 0) with memAck tied high, memReq rises at cycle 1 and pcLoad is at cycle 6.
- resetReqN low mid-sequence: the state aborts immediately, nothing is completed, and the reset sequence restarts.
- NMI edge coincident with an IRQ arbitration cycle: NMI wins, IRQ is re-evaluated later (level sensitive).

Decomposition:
- Shared package r88_pkg holds:
  - state encoding constants;
  - default vector constants (RESET/NMI/IRQ);
  - transfer-type constants (read/write).
- Sub-module r88_sync2 is the 2-flop synchroniser, instanced twice.

Test Plan:
- Release resetReqN, memAck = 1, mem[FFFC] = 34, mem[FFFD] = 12 -> reads FFFC then FFFD, pcLoad with newPc = 1234, setMask = 0, cpuHold falls afterwards.
- irq = 1, irqMask = 0, pc = ABCD, sp = 0200, flags = 5A, instrDone pulse -> writes AB@01FF, CD@01FE, 5A@01FD, 3 spDec pulses, vector read FFFE/FFFF, pcLoad, setMask = 1.
- irq = 1, irqMask = 1, repeated instrDone -> memReq stays 0, cpuHold stays 0.
- NMI edge plus irq = 1 at the same boundary -> first read address FFFA, NMI serviced first; IRQ is taken at the next boundary after the mask clears.
- memAck held low 5 cycles in PUSH_PCL -> memAddr/memWData stable, no spDec, state held; advances one edge after ack.
- resetReqN asserted during VEC_LO, sp = 0000 run -> push addresses FFFF/FFFE/FFFD before abort; after reset, the sequence restarts at FFFC with no pushes.

Source files
------------

// File: rtl/r88_pkg.sv
// Rocket88 interrupt sequencer shared definitions.
// State encoding, default vectors and transfer types.
package r88_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_FL,
    ST_VEC_LO,
    ST_VEC_HI,
    ST_LOAD_PC,
    ST_RST_VEC_LO,
    ST_RST_VEC_HI
  } r88_state_e;

  localparam logic [15:0] R88_RESET_VEC = 16'hFFFC;
  localparam logic [15:0] R88_NMI_VEC   = 16'hFFFA;
  localparam logic [15:0] R88_IRQ_VEC   = 16'hFFFE;

  localparam logic XFER_RD = 1'b0;
  localparam logic XFER_WR = 1'b1;

endpackage

// File: rtl/r88_sync2.sv
// Two-flop synchroniser for asynchronous request lines.
// Output is the second flop; reset clears both.
module r88_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/r88_int_sequencer.sv
// Rocket88 reset/NMI/IRQ sequencer: stacks PC and flags,
// fetches the vector and hands the new PC to the register block.
module r88_int_sequencer
  import r88_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = R88_RESET_VEC,
  parameter logic [15:0] NMI_VEC   = R88_NMI_VEC,
  parameter logic [15:0] IRQ_VEC   = R88_IRQ_VEC
) (
  input  logic        sysClock,
  input  logic        resetReqN,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqMask,
  input  logic        instrDone,
  input  logic [15:0] pc,
  input  logic [15:0] sp,
  input  logic [7:0]  flags,
  input  logic        memAck,
  input  logic [7:0]  memRData,
  output logic        memReq,
  output logic        memWe,
  output logic [15:0] memAddr,
  output logic [7:0]  memWData,
  output logic        spDec,
  output logic        pcLoad,
  output logic [15:0] newPc,
  output logic        setMask,
  output logic        cpuHold
);

  r88_state_e r_state;
  r88_state_e w_next;

  logic        r_live;
  logic        r_prevNmi;
  logic        r_nmiPend;
  logic        r_isRst;
  logic        r_spDec;
  logic [15:0] r_vec;
  logic [15:0] r_pc;
  logic [15:0] r_sp;
  logic [7:0]  r_flags;
  logic [15:0] r_newPc;

  logic        w_nmiSync;
  logic        w_irqSync;
  logic        w_nmiRise;
  logic        w_arb;
  logic        w_takeNmi;
  logic        w_takeIrq;
  logic        w_memSt;
  logic        w_req;
  logic        w_fire;
  logic        w_we;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;

  r88_sync2 u_nmi_sync (
    .i_clk   (sysClock),
    .i_rst_n (resetReqN),
    .i_d     (nmiReq),
    .o_q     (w_nmiSync)
  );

  r88_sync2 u_irq_sync (
    .i_clk   (sysClock),
    .i_rst_n (resetReqN),
    .i_d     (irq),
    .o_q     (w_irqSync)
  );

  assign w_nmiRise = w_nmiSync & ~r_prevNmi;
  assign w_arb     = (r_state == ST_IDLE) & instrDone;
  assign w_takeNmi = w_arb & (r_nmiPend | w_nmiRise);
  assign w_takeIrq = w_arb & ~w_takeNmi & w_irqSync & ~irqMask;

  assign w_memSt = (r_state != ST_IDLE) &&
                   (r_state != ST_LOAD_PC);
  // r_live keeps the bus quiet while reset is held
  assign w_req  = w_memSt & r_live;
  assign w_fire = w_req & memAck;

  always_comb begin
    w_next  = r_state;
    w_we    = XFER_RD;
    w_addr  = '0;
    w_wdata = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_takeNmi || w_takeIrq) w_next = ST_PUSH_PCH;
      end
      ST_PUSH_PCH: begin
        w_we    = XFER_WR;
        w_addr  = r_sp - 16'd1;
        w_wdata = r_pc[15:8];
        if (w_fire) w_next = ST_PUSH_PCL;
      end
      ST_PUSH_PCL: begin
        w_we    = XFER_WR;
        w_addr  = r_sp - 16'd2;
        w_wdata = r_pc[7:0];
        if (w_fire) w_next = ST_PUSH_FL;
      end
      ST_PUSH_FL: begin
        w_we    = XFER_WR;
        w_addr  = r_sp - 16'd3;
        w_wdata = r_flags;
        if (w_fire) w_next = ST_VEC_LO;
      end
      ST_VEC_LO: begin
        w_addr = r_vec;
        if (w_fire) w_next = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        w_addr = r_vec + 16'd1;
        if (w_fire) w_next = ST_LOAD_PC;
      end
      ST_LOAD_PC: begin
        w_next = ST_IDLE;
      end
      ST_RST_VEC_LO: begin
        w_addr = r_vec;
        if (w_fire) w_next = ST_RST_VEC_HI;
      end
      ST_RST_VEC_HI: begin
        w_addr = r_vec + 16'd1;
        if (w_fire) w_next = ST_LOAD_PC;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClock or negedge resetReqN) begin
    if (!resetReqN) begin
      r_state   <= ST_RST_VEC_LO;
      r_live    <= 1'b0;
      r_prevNmi <= 1'b0;
      r_nmiPend <= 1'b0;
      r_isRst   <= 1'b1;
      r_spDec   <= 1'b0;
      r_vec     <= RESET_VEC;
      r_pc      <= '0;
      r_sp      <= '0;
      r_flags   <= '0;
      r_newPc   <= '0;
    end else begin
      r_state   <= w_next;
      r_live    <= 1'b1;
      r_prevNmi <= w_nmiSync;
      r_spDec   <= w_fire & w_we;
      // a rise seen while one is already pending is dropped
      if (w_takeNmi) r_nmiPend <= 1'b0;
      else if (w_nmiRise) r_nmiPend <= 1'b1;
      if (w_takeNmi || w_takeIrq) begin
        r_pc    <= pc;
        r_sp    <= sp;
        r_flags <= flags;
        r_isRst <= 1'b0;
        r_vec   <= w_takeNmi ? NMI_VEC : IRQ_VEC;
      end
      if (w_fire && (r_state == ST_VEC_LO ||
                     r_state == ST_RST_VEC_LO))
        r_newPc[7:0] <= memRData;
      if (w_fire && (r_state == ST_VEC_HI ||
                     r_state == ST_RST_VEC_HI))
        r_newPc[15:8] <= memRData;
    end
  end

  assign memReq   = w_req;
  assign memWe    = w_req & w_we;
  assign memAddr  = w_req ? w_addr : '0;
  assign memWData = w_req ? w_wdata : '0;
  assign spDec    = r_spDec;
  assign pcLoad   = (r_state == ST_LOAD_PC);
  assign newPc    = r_newPc;
  assign setMask  = pcLoad & ~r_isRst;
  assign cpuHold  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_r88_int_sequencer.sv
// Scoreboard bench for r88_int_sequencer: expected bus
// transactions are queued by the driver and checked by a monitor.
module tb_r88_int_sequencer;

  logic        sysClock;
  logic        resetReqN;
  logic        nmiReq;
  logic        irq;
  logic        irqMask;
  logic        instrDone;
  logic [15:0] pc;
  logic [15:0] sp;
  logic [7:0]  flags;
  logic        memAck;
  logic [7:0]  memRData;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [7:0]  memWData;
  logic        spDec;
  logic        pcLoad;
  logic [15:0] newPc;
  logic        setMask;
  logic        cpuHold;

  logic [7:0] mem [0:65535];
  assign memRData = mem[memAddr];

  r88_int_sequencer dut (
    .sysClock  (sysClock),
    .resetReqN (resetReqN),
    .nmiReq    (nmiReq),
    .irq       (irq),
    .irqMask   (irqMask),
    .instrDone (instrDone),
    .pc        (pc),
    .sp        (sp),
    .flags     (flags),
    .memAck    (memAck),
    .memRData  (memRData),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .spDec     (spDec),
    .pcLoad    (pcLoad),
    .newPc     (newPc),
    .setMask   (setMask),
    .cpuHold   (cpuHold)
  );

  typedef struct {
    bit          ld;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] npc;
    bit          msk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;

  initial begin
    sysClock = 0;
    forever #5 sysClock = ~sysClock;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClock);
    #1;
  endtask

  // ack generator: 0 = always, 1 = random, 2 = driven by hand
  initial begin
    forever begin
      @(posedge sysClock);
      #1;
      if (mode == 0) memAck = 1'b1;
      else if (mode == 1) memAck = ($urandom % 3) != 0;
    end
  end

  task automatic exp_mem(input bit we, input logic [15:0] a,
                         input logic [7:0] d);
    exp_t e;
    e = '{ld: 0, we: we, addr: a, data: d, npc: 16'h0, msk: 0};
    q.push_back(e);
  endtask

  task automatic exp_ld(input logic [15:0] v, input bit m);
    exp_t e;
    logic [15:0] hi;
    hi = v + 16'd1;
    e = '{ld: 1, we: 0, addr: 16'h0, data: 8'h0,
          npc: {mem[hi], mem[v]}, msk: m};
    q.push_back(e);
  endtask

  task automatic exp_int(input logic [15:0] v, input logic [15:0] p,
                         input logic [15:0] s, input logic [7:0] f);
    exp_mem(1, s - 16'd1, p[15:8]);
    exp_mem(1, s - 16'd2, p[7:0]);
    exp_mem(1, s - 16'd3, f);
    exp_mem(0, v, 8'h0);
    exp_mem(0, v + 16'd1, 8'h0);
    exp_ld(v, 1);
  endtask

  task automatic exp_rst();
    exp_mem(0, 16'hFFFC, 8'h0);
    exp_mem(0, 16'hFFFD, 8'h0);
    exp_ld(16'hFFFC, 0);
  endtask

  // monitor
  initial begin
    bit   sd_exp;
    exp_t e;
    sd_exp = 0;
    forever begin
      @(negedge sysClock);
      if (!resetReqN) sd_exp = 0;
      else begin
        if (spDec || sd_exp) chk("spDec", {31'b0, spDec}, {31'b0, sd_exp});
        sd_exp = memReq && memAck && memWe;
        if (memReq && memAck) begin
          if (q.size() == 0 || q[0].ld) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer addr=%h we=%b", memAddr, memWe);
          end else begin
            e = q.pop_front();
            chk("xfer_we", {31'b0, memWe}, {31'b0, e.we});
            chk("xfer_addr", {16'b0, memAddr}, {16'b0, e.addr});
            if (e.we) chk("xfer_wdata", {24'b0, memWData}, {24'b0, e.data});
          end
        end
        if (pcLoad) begin
          if (q.size() == 0 || !q[0].ld) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pcLoad newPc=%h", newPc);
          end else begin
            e = q.pop_front();
            chk("newPc", {16'b0, newPc}, {16'b0, e.npc});
            chk("setMask", {31'b0, setMask}, {31'b0, e.msk});
            chk("load_noreq", {31'b0, memReq}, 32'd0);
          end
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (cpuHold && n < 300) begin
      tick();
      n++;
    end
    chk({nm, "_idle"}, {31'b0, cpuHold}, 32'd0);
    chk({nm, "_drained"}, q.size(), 32'd0);
  endtask

  task automatic pulse_done();
    instrDone = 1;
    tick();
    instrDone = 0;
  endtask

  task automatic rand_vecs();
    for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
  endtask

  initial begin
    logic [15:0] a0;
    logic [7:0]  d0;
    int          n;
    resetReqN = 0; nmiReq = 0; irq = 0; irqMask = 0; instrDone = 0;
    pc = 0; sp = 0; flags = 0; memAck = 1; mode = 0;
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hA0;
    tick(); tick();
    chk("rst_memReq", {31'b0, memReq}, 32'd0);
    chk("rst_memWe", {31'b0, memWe}, 32'd0);
    chk("rst_memAddr", {16'b0, memAddr}, 32'd0);
    chk("rst_memWData", {24'b0, memWData}, 32'd0);
    chk("rst_newPc", {16'b0, newPc}, 32'd0);
    chk("rst_pulses", {29'b0, spDec, pcLoad, setMask}, 32'd0);
    chk("rst_cpuHold", {31'b0, cpuHold}, 32'd1);

    exp_rst();
    resetReqN = 1;
    wait_idle("reset_seq");

    irq = 1; irqMask = 0; pc = 16'hABCD; sp = 16'h0200; flags = 8'h5A;
    tick(); tick(); tick();
    exp_int(16'hFFFE, pc, sp, flags);
    pulse_done();
    wait_idle("irq_basic");
    irqMask = 1;

    for (int i = 0; i < 4; i++) begin
      pulse_done();
      chk("masked_req", {31'b0, memReq}, 32'd0);
      chk("masked_hold", {31'b0, cpuHold}, 32'd0);
      tick();
    end

    nmiReq = 1; irqMask = 0; pc = 16'h4321; sp = 16'h1000; flags = 8'h81;
    tick(); tick(); tick(); tick();
    exp_int(16'hFFFA, pc, sp, flags);
    pulse_done();
    wait_idle("nmi_vs_irq");
    nmiReq = 0;
    irqMask = 1;
    pulse_done();
    chk("masked_after_nmi", {31'b0, cpuHold}, 32'd0);
    irqMask = 0; pc = 16'h4400;
    tick();
    exp_int(16'hFFFE, pc, sp, flags);
    pulse_done();
    wait_idle("irq_after_nmi");
    irq = 0; irqMask = 1;

    mode = 2; memAck = 0;
    irq = 1; irqMask = 0; pc = 16'h1357; sp = 16'h8000; flags = 8'hC3;
    tick(); tick(); tick();
    exp_int(16'hFFFE, pc, sp, flags);
    pulse_done();
    memAck = 1;
    tick();
    memAck = 0;
    a0 = memAddr;
    d0 = memWData;
    chk("stall_addr", {16'b0, a0}, 32'h7FFE);
    chk("stall_data", {24'b0, d0}, 32'h57);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_addr", {16'b0, memAddr}, {16'b0, a0});
      chk("stall_hold_data", {24'b0, memWData}, {24'b0, d0});
      chk("stall_req", {31'b0, memReq}, 32'd1);
      chk("stall_nospdec", {31'b0, spDec}, 32'd0);
    end
    memAck = 1;
    tick();
    chk("stall_advance", {16'b0, memAddr}, 32'h7FFD);
    mode = 0;
    wait_idle("stall");
    irq = 0; irqMask = 1;

    mode = 1;
    for (int i = 0; i < 24; i++) begin
      bit isNmi;
      rand_vecs();
      isNmi = $urandom % 2;
      pc = 16'($urandom); sp = 16'($urandom); flags = 8'($urandom);
      if (i == 3) sp = 16'h0001;
      if (isNmi) begin
        nmiReq = 1;
        irq = $urandom % 2;
        irqMask = $urandom % 2;
        tick(); tick(); tick(); tick();
        exp_int(16'hFFFA, pc, sp, flags);
      end else begin
        irq = 1; irqMask = 0;
        tick(); tick(); tick();
        exp_int(16'hFFFE, pc, sp, flags);
      end
      pulse_done();
      wait_idle(isNmi ? "rand_nmi" : "rand_irq");
      nmiReq = 0; irq = 0; irqMask = 1;
      tick(); tick(); tick();
    end

    mode = 2; memAck = 1;
    irq = 1; irqMask = 0; pc = 16'h2468; sp = 16'h0000; flags = 8'h0F;
    tick(); tick(); tick();
    exp_int(16'hFFFE, pc, sp, flags);
    pulse_done();
    n = 0;
    while (!(memReq && !memWe && memAddr == 16'hFFFE) && n < 50) begin
      tick();
      n++;
    end
    memAck = 0;
    chk("abort_at_veclo", {31'b0, memReq && !memWe}, 32'd1);
    chk("abort_pending", q.size(), 32'd3);
    resetReqN = 0;
    #1;
    chk("abort_req", {31'b0, memReq}, 32'd0);
    chk("abort_hold", {31'b0, cpuHold}, 32'd1);
    q.delete();
    irq = 0;
    tick(); tick();
    mem[16'hFFFC] = 8'h78; mem[16'hFFFD] = 8'h56;
    exp_rst();
    mode = 0;
    resetReqN = 1;
    wait_idle("reset_restart");

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
